tdm_demux_4: RTL and testbench

- Receive end of a time-division-multiplexed nibble link, the inverse of the board-level 2:1 multiplexer.
- Accepts one WIDTH-bit beat per valid cycle on a single shared bus. A sync strobe marks slot 0.
- Beats are steered into per-slot shadow registers; the complete frame is presented in parallel on DOUT with a one-cycle DVALID pulse.
- Sits between a serial/TDM source (switch stepper or upstream mux) and LEDR/7-segment display logic.

---
 rtl/tdm_pkg.sv | 17 +
 rtl/tdm_slot_ctr.sv | 35 +++
 rtl/tdm_demux_4.sv | 135 +++++++++++++
 tb/tb_tdm_demux_4.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM receive demultiplexer.
package tdm_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_SLOTS = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // A slot index needs at least one bit, even for degenerate slot counts.
  function automatic int unsigned slot_bits(input int unsigned slots);
    return (slots > 2) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Modulo-SLOTS slot index counter with load-to-1, clear and last-slot flag.
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int unsigned SLOTS = DEF_SLOTS,
  parameter int unsigned SW    = slot_bits(SLOTS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load1,
  input  logic          clr,
  output logic [SW-1:0] count,
  output logic          last
);

  localparam logic [SW-1:0] LAST_IDX = SW'(SLOTS - 1);
  localparam logic [SW-1:0] ONE      = SW'(1);

  // Clear outranks load, which outranks a plain increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load1) begin
      count <= ONE;
    end else if (en) begin
      count <= last ? '0 : count + ONE;
    end
  end

  assign last = (count == LAST_IDX);

endmodule

// File: rtl/tdm_demux_4.sv
// TDM receive demultiplexer: steers SYNC-aligned beats into per-slot shadows
// and publishes each complete frame on dout with a one-cycle dvalid pulse.
module tdm_demux_4
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLOTS = DEF_SLOTS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            sdata,
  input  logic                        svalid,
  input  logic                        sync,
  output logic [SLOTS*WIDTH-1:0]      dout,
  output logic                        dvalid,
  output logic [slot_bits(SLOTS)-1:0] slot,
  output logic                        sync_err
);

  localparam int unsigned SW = slot_bits(SLOTS);

  if (SLOTS < 2 || SLOTS > 16) begin : g_bad_slots
    $error("tdm_demux_4: SLOTS must be within 2..16");
  end

  state_t state_q, state_d;

  logic          ctr_en, ctr_load1, ctr_clr, ctr_last;
  logic          wr_en, set_err, frame_done;
  logic [SW-1:0] wr_idx;

  logic [WIDTH-1:0]       shadow [SLOTS];
  logic [SLOTS*WIDTH-1:0] frame;

  tdm_slot_ctr #(
    .SLOTS (SLOTS),
    .SW    (SW)
  ) u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .en    (ctr_en),
    .load1 (ctr_load1),
    .clr   (ctr_clr),
    .count (slot),
    .last  (ctr_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctr_en     = 1'b0;
    ctr_load1  = 1'b0;
    ctr_clr    = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = slot;
    set_err    = 1'b0;
    frame_done = 1'b0;
    if (svalid) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            wr_en     = 1'b1;
            wr_idx    = '0;
            ctr_load1 = 1'b1;
            state_d   = LOCKED;
          end
        end
        LOCKED: begin
          if (sync) begin
            // An early sync restarts the frame; stale upper shadows are
            // harmless because every slot is rewritten before completion.
            wr_en     = 1'b1;
            wr_idx    = '0;
            ctr_load1 = 1'b1;
            set_err   = (slot != '0);
          end else if (slot == '0) begin
            set_err = 1'b1;
            state_d = HUNT;
          end else begin
            wr_en = 1'b1;
            if (ctr_last) begin
              frame_done = 1'b1;
              ctr_clr    = 1'b1;
            end else begin
              ctr_en = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        shadow[i] <= '0;
      end
    end else if (wr_en) begin
      shadow[wr_idx] <= sdata;
    end
  end

  // The final slot bypasses its shadow so the frame publishes on the same edge.
  always_comb begin
    frame = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      frame[i*WIDTH +: WIDTH] = (i == SLOTS - 1) ? sdata : shadow[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout     <= '0;
      dvalid   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      dvalid <= frame_done;
      if (frame_done) begin
        dout <= frame;
      end
      if (set_err) begin
        sync_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_4.sv
// Scoreboard bench for tdm_demux_4: expected frames are queued at stimulus
// time and popped by an independent monitor on each dvalid pulse.
module tb_tdm_demux_4;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned SLOTS = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] sdata = '0;
  logic             svalid = 1'b0;
  logic             sync = 1'b0;
  logic [7:0]       dout;
  logic             dvalid;
  logic [0:0]       slot;
  logic             sync_err;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [7:0]  expq[$];

  tdm_demux_4 #(
    .WIDTH (WIDTH),
    .SLOTS (SLOTS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sdata    (sdata),
    .svalid   (svalid),
    .sync     (sync),
    .dout     (dout),
    .dvalid   (dvalid),
    .slot     (slot),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every dvalid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (!rst && dvalid) begin
      if (expq.size() == 0) begin
        total++;
        $display("FAIL unexpected_dvalid: got dout 0x%0h with no frame expected", dout);
      end else begin
        check("frame_dout", 32'(dout), 32'(expq.pop_front()));
      end
    end
  end

  // Called at a negedge; leaves the beat on the bus for exactly one posedge.
  task automatic beat(input logic s, input logic [WIDTH-1:0] d);
    svalid = 1'b1;
    sync   = s;
    sdata  = d;
    @(negedge clk);
    svalid = 1'b0;
    sync   = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    idle(2);
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_dvalid", 32'(dvalid), 32'h0);
    check("rst_slot", 32'(slot), 32'h0);
    check("rst_sync_err", 32'(sync_err), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Basic frame
    beat(1'b1, 4'h3);
    expq.push_back(8'hA3);
    beat(1'b0, 4'hA);
    idle(2);
    check("t1_sync_err", 32'(sync_err), 32'h0);
    check("t1_slot", 32'(slot), 32'h0);

    // Frame with an idle gap between beats
    beat(1'b1, 4'h3);
    idle(3);
    check("t2_gap_slot", 32'(slot), 32'h1);
    expq.push_back(8'hA3);
    beat(1'b0, 4'hA);
    idle(2);
    check("t2_slot", 32'(slot), 32'h0);

    // Back-to-back frames
    beat(1'b1, 4'h1);
    expq.push_back(8'h21);
    beat(1'b0, 4'h2);
    beat(1'b1, 4'h3);
    expq.push_back(8'h43);
    beat(1'b0, 4'h4);
    idle(2);

    // Beats without sync after reset are ignored
    pulse_reset();
    beat(1'b0, 4'h5);
    beat(1'b0, 4'h6);
    idle(2);
    check("t3_dout", 32'(dout), 32'h00);
    check("t3_sync_err", 32'(sync_err), 32'h0);
    check("t3_slot", 32'(slot), 32'h0);

    // Early sync
    pulse_reset();
    beat(1'b1, 4'h1);
    beat(1'b1, 4'h2);
    check("t4_err_after_early", 32'(sync_err), 32'h1);
    check("t4_slot_after_early", 32'(slot), 32'h1);
    expq.push_back(8'h72);
    beat(1'b0, 4'h7);
    idle(2);
    check("t4_sync_err", 32'(sync_err), 32'h1);

    // Missing sync, then recovery
    pulse_reset();
    beat(1'b1, 4'h3);
    expq.push_back(8'hA3);
    beat(1'b0, 4'hA);
    beat(1'b0, 4'h9);
    idle(2);
    check("t5_sync_err", 32'(sync_err), 32'h1);
    check("t5_dout_hold", 32'(dout), 32'hA3);
    check("t5_slot", 32'(slot), 32'h0);
    beat(1'b0, 4'h5);
    idle(1);
    check("t5_hunt_slot", 32'(slot), 32'h0);
    beat(1'b1, 4'h1);
    expq.push_back(8'h21);
    beat(1'b0, 4'h2);
    idle(2);
    check("t5_recover_dout", 32'(dout), 32'h21);
    check("t5_err_sticky", 32'(sync_err), 32'h1);

    // Mid-frame reset discards partial frame
    pulse_reset();
    beat(1'b1, 4'h4);
    check("t6_slot_before_rst", 32'(slot), 32'h1);
    pulse_reset();
    beat(1'b0, 4'h8);
    idle(2);
    check("t6_dout", 32'(dout), 32'h00);
    check("t6_slot", 32'(slot), 32'h0);
    check("t6_sync_err", 32'(sync_err), 32'h0);

    // Drain scoreboard with a bounded wait
    for (int unsigned i = 0; i < 20 && expq.size() != 0; i++) @(negedge clk);
    check("scoreboard_empty", 32'(expq.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
